// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared types and helpers for the TDM demultiplexer slice.
//   tdm_state_t : receiver state (HUNT = waiting for a sync word,
//                 RUN = partial frame in progress)
//   slot_width  : width of the binary slot counter for a given channel count
//   N_CH_MIN/MAX: legal channel-count range
// ----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

    localparam int unsigned N_CH_MIN = 2;
    localparam int unsigned N_CH_MAX = 16;

    // clog2 of the channel count, never narrower than one bit
    function automatic int unsigned slot_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// ----------------------------------------------------------------------------
// tdm_slot_decoder
// Combinational binary-to-one-hot decoder producing shadow-buffer write
// enables.
//   slot : binary slot index (SLOT_W bits)
//   en   : write this cycle
//   we   : one-hot write enable, bit k set when en and slot == k
// ----------------------------------------------------------------------------
module tdm_slot_decoder
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned SLOT_W = slot_width(N_CH)
) (
    input  logic [SLOT_W-1:0] slot,
    input  logic              en,
    output logic [N_CH-1:0]   we
);

    always_comb begin
        we = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            we[k] = en && (slot == SLOT_W'(k));
        end
    end

endmodule

// File: rtl/tdm_demuxer.sv
// ----------------------------------------------------------------------------
// tdm_demuxer
// Receiving end of a TDM link: collects N_CH words (slot 0 flagged by
// frame_sync) into a shadow buffer and publishes the complete frame to
// out_data atomically.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   in_valid     : word present on in_data
//   frame_sync   : word is slot 0 of a new frame (qualified by in_valid)
//   in_data      : W-bit lane data
//   in_parity    : even parity over in_data (only with TDM_DEMUX_PARITY_EN)
//   out_data     : last complete frame, channel k at bits [k*W +: W]
//   out_valid    : one-cycle pulse when out_data has just been updated
//   frame_err    : one-cycle pulse on premature sync or parity error
//   busy         : partial frame in progress
// Optional feature macro: TDM_DEMUX_PARITY_EN
// ----------------------------------------------------------------------------
module tdm_demuxer
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              frame_sync,
    input  logic [W-1:0]      in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic              in_parity,
`endif
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned       SLOT_W    = slot_width(N_CH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("tdm_demuxer: N_CH out of legal range");
    end

    tdm_state_t        state, state_next;
    logic [SLOT_W-1:0] slot, slot_next;
    logic [N_CH*W-1:0] shadow, shadow_next;
    logic [SLOT_W-1:0] wr_idx;
    logic              wr_go;
    logic              publish;
    logic              err;
    logic              parity_ok;
    logic [N_CH-1:0]   we;

`ifdef TDM_DEMUX_PARITY_EN
    assign parity_ok = ((^in_data) == in_parity);
`else
    assign parity_ok = 1'b1;
`endif

    assign busy = (state == RUN);

    tdm_slot_decoder #(
        .N_CH   (N_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_decoder (
        .slot (wr_idx),
        .en   (wr_go),
        .we   (we)
    );

    always_comb begin
        state_next = state;
        slot_next  = slot;
        wr_idx     = slot;
        wr_go      = 1'b0;
        publish    = 1'b0;
        err        = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    // non-sync words are dropped silently while hunting
                    if (frame_sync) begin
                        if (parity_ok) begin
                            wr_idx     = '0;
                            wr_go      = 1'b1;
                            slot_next  = SLOT_W'(1);
                            state_next = RUN;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!parity_ok) begin
                        err        = 1'b1;
                        slot_next  = '0;
                        state_next = HUNT;
                    end else if (frame_sync) begin
                        // premature sync restarts the frame at slot 0
                        err       = 1'b1;
                        wr_idx    = '0;
                        wr_go     = 1'b1;
                        slot_next = SLOT_W'(1);
                    end else begin
                        wr_go = 1'b1;
                        if (slot == LAST_SLOT) begin
                            publish    = 1'b1;
                            slot_next  = '0;
                            state_next = HUNT;
                        end else begin
                            slot_next = slot + SLOT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                    slot_next  = '0;
                end
            endcase
        end
    end

    // merged view of the shadow including the word written this cycle, so the
    // last slot reaches out_data at the same edge it is accepted
    always_comb begin
        shadow_next = shadow;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (we[k]) begin
                shadow_next[k*W +: W] = in_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            slot      <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            slot      <= slot_next;
            shadow    <= shadow_next;
            out_valid <= publish;
            frame_err <= err;
            if (publish) begin
                out_data <= shadow_next;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demuxer.sv
// ----------------------------------------------------------------------------
// tb_tdm_demuxer
// Self-checking bench for tdm_demuxer (N_CH=4, W=8). A frame-level reference
// model (queue of collected words) predicts out_data/out_valid/frame_err/busy
// after every clock edge. Build with +define+TDM_DEMUX_PARITY_EN to exercise
// the parity option.
// ----------------------------------------------------------------------------
module tb_tdm_demuxer;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              frame_sync = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic              in_parity = 1'b0;
    logic [N_CH*W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit                m_in_frame = 1'b0;
    logic [W-1:0]      m_words[$];
    logic [N_CH*W-1:0] m_data = '0;
    logic              m_valid = 1'b0;
    logic              m_err = 1'b0;

    tdm_demuxer #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .in_data    (in_data),
`ifdef TDM_DEMUX_PARITY_EN
        .in_parity  (in_parity),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_words.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // frame-level behaviour: what one accepted/ignored beat does to the frame
    task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit par_ok);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!v) return;
        if (!m_in_frame && !s) return;
        if (!par_ok) begin
            m_err      = 1'b1;
            m_in_frame = 1'b0;
            m_words.delete();
            return;
        end
        if (s) begin
            if (m_in_frame) m_err = 1'b1;
            m_words.delete();
            m_words.push_back(d);
            m_in_frame = 1'b1;
        end else begin
            m_words.push_back(d);
            if (m_words.size() == N_CH) begin
                m_data = '0;
                for (int i = 0; i < N_CH; i++) begin
                    m_data = m_data | ((N_CH*W)'(m_words[i]) << (i * W));
                end
                m_valid    = 1'b1;
                m_in_frame = 1'b0;
                m_words.delete();
            end
        end
    endtask

    // one clock: drive inputs away from the edge, advance model, check after edge
    task automatic cycle(input bit v, input bit s, input logic [W-1:0] d, input bit bad_par);
        bit par_ok;
        in_valid   = v;
        frame_sync = s;
        in_data    = d;
        in_parity  = (^d) ^ bad_par;
`ifdef TDM_DEMUX_PARITY_EN
        par_ok = !bad_par;
`else
        par_ok = 1'b1;
`endif
        @(posedge clock);
        model_step(v, s, d, par_ok);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("busy", 64'(busy), 64'(m_in_frame));
        check("out_data", 64'(out_data), 64'(m_data));
        check("valid_err_excl", 64'(out_valid & frame_err), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom), 1'b0);
    endtask

    initial begin
        int gap_cycles;
        model_reset();
        #1;
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // basic frame on consecutive cycles
        cycle(1, 1, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 0, 8'h33, 0);
        cycle(1, 0, 8'h44, 0);
        check("frame1_valid", 64'(out_valid), 64'd1);
        check("frame1_data", 64'(out_data), 64'h44332211);
        idle(1);
        check("frame1_valid_one_cycle", 64'(out_valid), 64'd0);
        check("frame1_busy_after", 64'(busy), 64'd0);
        check("frame1_data_held", 64'(out_data), 64'h44332211);

        // same frame with 3 idle cycles between slots 1 and 2
        cycle(1, 1, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        gap_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 0);
            if (busy) gap_cycles++;
        end
        check("gap_busy_held", 64'(gap_cycles), 64'd3);
        cycle(1, 0, 8'h33, 0);
        check("gap_no_early_valid", 64'(out_valid), 64'd0);
        cycle(1, 0, 8'h44, 0);
        check("gap_frame_valid", 64'(out_valid), 64'd1);
        check("gap_frame_data", 64'(out_data), 64'h44332211);

        // premature sync aborts the partial frame
        cycle(1, 1, 8'hAA, 0);
        cycle(1, 0, 8'hBB, 0);
        cycle(1, 1, 8'h01, 0);
        check("abort_err", 64'(frame_err), 64'd1);
        check("abort_data_kept", 64'(out_data), 64'h44332211);
        cycle(1, 0, 8'h02, 0);
        cycle(1, 0, 8'h03, 0);
        cycle(1, 0, 8'h04, 0);
        check("abort_next_data", 64'(out_data), 64'h04030201);

        // non-sync word while hunting is ignored; then back-to-back frames
        cycle(1, 0, 8'h55, 0);
        check("hunt_drop_no_err", 64'(frame_err), 64'd0);
        check("hunt_drop_busy", 64'(busy), 64'd0);
        cycle(1, 1, 8'hA0, 0);
        cycle(1, 0, 8'hA1, 0);
        cycle(1, 0, 8'hA2, 0);
        cycle(1, 0, 8'hA3, 0);
        cycle(1, 1, 8'hB0, 0);
        check("b2b_sync_accepted", 64'(busy), 64'd1);
        cycle(1, 0, 8'hB1, 0);
        cycle(1, 0, 8'hB2, 0);
        cycle(1, 0, 8'hB3, 0);
        check("b2b_data", 64'(out_data), 64'hB3B2B1B0);

        // asynchronous reset mid-frame
        cycle(1, 1, 8'hC0, 0);
        cycle(1, 0, 8'hC1, 0);
        cycle(1, 0, 8'hC2, 0);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_out_data", 64'(out_data), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_err", 64'(frame_err), 64'd0);
        #1;
        reset = 1'b0;
        cycle(1, 0, 8'hC3, 0);
        check("post_rst_drop", 64'(busy), 64'd0);
        cycle(1, 1, 8'hD0, 0);
        cycle(1, 0, 8'hD1, 0);
        cycle(1, 0, 8'hD2, 0);
        cycle(1, 0, 8'hD3, 0);
        check("post_rst_data", 64'(out_data), 64'hD3D2D1D0);

`ifdef TDM_DEMUX_PARITY_EN
        // bad parity on slot 1 returns to HUNT
        cycle(1, 1, 8'h10, 0);
        cycle(1, 0, 8'h11, 1);
        check("par_err", 64'(frame_err), 64'd1);
        check("par_hunt", 64'(busy), 64'd0);
        check("par_data_kept", 64'(out_data), 64'hD3D2D1D0);
        cycle(1, 0, 8'h12, 0);
        cycle(1, 1, 8'h20, 1);
        check("par_sync_err", 64'(frame_err), 64'd1);
        check("par_sync_hunt", 64'(busy), 64'd0);
        cycle(1, 1, 8'h20, 0);
        cycle(1, 0, 8'h21, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 0, 8'h23, 0);
        check("par_recover_data", 64'(out_data), 64'h23222120);
`endif

        // randomized traffic against the frame model
        for (int i = 0; i < 600; i++) begin
            bit v, s, bp;
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 5) == 0);
            bp = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            bp = ($urandom_range(0, 19) == 0);
`endif
            cycle(v, s, W'($urandom), bp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
